// File: rtl/msrv32_pkg.sv
// Shared definitions for the RV32 address-generation path: access-size
// encodings, requester indices and the alignment rule.
package msrv32_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_NONE = 2'b11
  } size_e;

  // rq0 is the branch/jump unit, rq1 the load/store unit.
  typedef enum logic {
    RQ_BRU = 1'b0,
    RQ_LSU = 1'b1
  } rq_id_e;

  // Only the two address LSBs matter; byte and "no access" never fault.
  function automatic logic addr_misaligned(input size_e size, input logic [1:0] addr_lsb);
    logic mis;
    mis = 1'b0;
    case (size)
      SZ_HALF: mis = addr_lsb[0];
      SZ_WORD: mis = (addr_lsb != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/msrv32_immediate_adder.sv
// Address adder: base (pc or rs1) plus immediate, wrapping modulo 2^XLEN.
module msrv32_immediate_adder #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic            src_i,
  output logic [XLEN-1:0] sum_o
);

  // Carry out of the top bit is deliberately dropped.
  assign sum_o = (src_i ? rs1_i : pc_i) + imm_i;

endmodule

// File: rtl/msrv32_iadder_arbiter.sv
// Two-requester round-robin arbiter in front of a single shared address
// adder, with a one-deep registered output stage and valid/ready handshake.
module msrv32_iadder_arbiter
  import msrv32_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RST_ADDR = '0
) (
  input  logic            ms_riscv32_mp_clk_in,
  input  logic            ms_riscv32_mp_rst_in,

  input  logic            rq0_valid_in,
  output logic            rq0_ready_out,
  input  logic [XLEN-1:0] rq0_pc_in,
  input  logic [XLEN-1:0] rq0_rs1_in,
  input  logic [XLEN-1:0] rq0_imm_in,
  input  logic            rq0_src_in,
  input  logic [1:0]      rq0_size_in,

  input  logic            rq1_valid_in,
  output logic            rq1_ready_out,
  input  logic [XLEN-1:0] rq1_pc_in,
  input  logic [XLEN-1:0] rq1_rs1_in,
  input  logic [XLEN-1:0] rq1_imm_in,
  input  logic            rq1_src_in,
  input  logic [1:0]      rq1_size_in,

  output logic            out_valid_out,
  input  logic            out_ready_in,
  output logic [XLEN-1:0] out_addr_out,
  output logic            out_id_out,
  output logic            out_misaligned_out
);

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_addr_q,  out_addr_d;
  rq_id_e          out_id_q,    out_id_d;
  logic            out_mis_q,   out_mis_d;
  rq_id_e          last_gnt_q,  last_gnt_d;

  rq_id_e          gnt;
  logic            stage_free;
  logic            accept;
  logic [XLEN-1:0] sel_pc, sel_rs1, sel_imm, sum;
  logic            sel_src;
  logic [1:0]      sel_size;

  // A lone requester wins outright; on a tie the one not served last wins.
  always_comb begin
    gnt = RQ_BRU;
    if (rq0_valid_in && rq1_valid_in) begin
      gnt = (last_gnt_q == RQ_BRU) ? RQ_LSU : RQ_BRU;
    end else if (rq1_valid_in) begin
      gnt = RQ_LSU;
    end
  end

  assign stage_free = !out_valid_q || out_ready_in;
  // NOTE: reset gates the accept path combinationally so no ready leaks out
  // while reset is held, even between clock edges.
  assign accept = stage_free && (rq0_valid_in || rq1_valid_in) && !ms_riscv32_mp_rst_in;

  assign rq0_ready_out = accept && (gnt == RQ_BRU);
  assign rq1_ready_out = accept && (gnt == RQ_LSU);

  always_comb begin
    if (gnt == RQ_LSU) begin
      sel_pc   = rq1_pc_in;
      sel_rs1  = rq1_rs1_in;
      sel_imm  = rq1_imm_in;
      sel_src  = rq1_src_in;
      sel_size = rq1_size_in;
    end else begin
      sel_pc   = rq0_pc_in;
      sel_rs1  = rq0_rs1_in;
      sel_imm  = rq0_imm_in;
      sel_src  = rq0_src_in;
      sel_size = rq0_size_in;
    end
  end

  msrv32_immediate_adder #(
    .XLEN (XLEN)
  ) u_iadder (
    .pc_i  (sel_pc),
    .rs1_i (sel_rs1),
    .imm_i (sel_imm),
    .src_i (sel_src),
    .sum_o (sum)
  );

  // NOTE: every next-state signal gets its hold value first, so no path
  // through this block can infer a latch.
  always_comb begin
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_id_d    = out_id_q;
    out_mis_d   = out_mis_q;
    last_gnt_d  = last_gnt_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_addr_d  = sum;
      out_id_d    = gnt;
      out_mis_d   = addr_misaligned(size_e'(sel_size), sum[1:0]);
      last_gnt_d  = gnt;
    end else if (out_ready_in) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update
  // from the same pre-edge values.
  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) begin
      out_valid_q <= 1'b0;
      out_addr_q  <= RST_ADDR;
      out_id_q    <= RQ_BRU;
      out_mis_q   <= 1'b0;
      last_gnt_q  <= RQ_LSU;
    end else begin
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_id_q    <= out_id_d;
      out_mis_q   <= out_mis_d;
      last_gnt_q  <= last_gnt_d;
    end
  end

  assign out_valid_out      = out_valid_q;
  assign out_addr_out       = out_addr_q;
  assign out_id_out         = out_id_q;
  assign out_misaligned_out = out_mis_q;

endmodule

// File: tb/tb_msrv32_iadder_arbiter.sv
// Bench for msrv32_iadder_arbiter: directed stimulus with literal expectations
// plus a cycle-by-cycle reference model compared on every falling edge.
module tb_msrv32_iadder_arbiter;

  localparam logic [31:0] RST_A = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v0 = 1'b0, v1 = 1'b0, r0, r1;
  logic [31:0] pc0 = '0, rs10 = '0, imm0 = '0, pc1 = '0, rs11 = '0, imm1 = '0;
  logic        src0 = 1'b0, src1 = 1'b0;
  logic [1:0]  sz0 = 2'd0, sz1 = 2'd0;
  logic        o_valid, o_ready = 1'b1, o_id, o_mis;
  logic [31:0] o_addr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  msrv32_iadder_arbiter #(.XLEN(32), .RST_ADDR(RST_A)) dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst),
    .rq0_valid_in         (v0),
    .rq0_ready_out        (r0),
    .rq0_pc_in            (pc0),
    .rq0_rs1_in           (rs10),
    .rq0_imm_in           (imm0),
    .rq0_src_in           (src0),
    .rq0_size_in          (sz0),
    .rq1_valid_in         (v1),
    .rq1_ready_out        (r1),
    .rq1_pc_in            (pc1),
    .rq1_rs1_in           (rs11),
    .rq1_imm_in           (imm1),
    .rq1_src_in           (src1),
    .rq1_size_in          (sz1),
    .out_valid_out        (o_valid),
    .out_ready_in         (o_ready),
    .out_addr_out         (o_addr),
    .out_id_out           (o_id),
    .out_misaligned_out   (o_mis)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the output stage as "holding a result or not", and the
  // round-robin rule as "on a tie, serve whoever was not served last".
  logic        m_valid = 1'b0, m_id = 1'b0, m_mis = 1'b0;
  logic [31:0] m_addr = RST_A, a;
  int          m_last = 1, win;
  logic        free;
  logic [1:0]  sz;

  always @(negedge clk) begin
    if (rst) begin
      m_valid = 1'b0; m_addr = RST_A; m_id = 1'b0; m_mis = 1'b0; m_last = 1;
      check("mdl_rst_ready0", {31'd0, r0}, 32'd0);
      check("mdl_rst_ready1", {31'd0, r1}, 32'd0);
      check("mdl_rst_valid", {31'd0, o_valid}, 32'd0);
      check("mdl_rst_addr", o_addr, RST_A);
    end else begin
      free = !m_valid || o_ready;
      win = -1;
      if (v0 && v1) win = (m_last == 1) ? 0 : 1;
      else if (v0)  win = 0;
      else if (v1)  win = 1;
      check("mdl_ready0", {31'd0, r0}, {31'd0, free && win == 0});
      check("mdl_ready1", {31'd0, r1}, {31'd0, free && win == 1});
      check("mdl_valid", {31'd0, o_valid}, {31'd0, m_valid});
      if (m_valid) begin
        check("mdl_addr", o_addr, m_addr);
        check("mdl_id", {31'd0, o_id}, {31'd0, m_id});
        check("mdl_mis", {31'd0, o_mis}, {31'd0, m_mis});
      end
      if (free && win >= 0) begin
        if (win == 0) begin a = (src0 ? rs10 : pc0) + imm0; sz = sz0; end
        else          begin a = (src1 ? rs11 : pc1) + imm1; sz = sz1; end
        m_valid = 1'b1;
        m_addr  = a;
        m_id    = (win == 1);
        m_mis   = (sz == 2'd1) ? (a % 2 != 0) : (sz == 2'd2) ? (a % 4 != 0) : 1'b0;
        m_last  = win;
      end else if (o_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic [31:0] pc, rs1, imm, input logic src, input logic [1:0] size);
    pc0 = pc; rs10 = rs1; imm0 = imm; src0 = src; sz0 = size;
  endtask

  task automatic set1(input logic [31:0] pc, rs1, imm, input logic src, input logic [1:0] size);
    pc1 = pc; rs11 = rs1; imm1 = imm; src1 = src; sz1 = size;
  endtask

  logic [31:0] t_imm [6] = '{32'h2, 32'h2, 32'h1, 32'h1, 32'h1, 32'h3};
  logic [1:0]  t_sz  [6] = '{2'd2, 2'd1, 2'd1, 2'd0, 2'd3, 2'd2};
  logic        t_mis [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    // Reset state
    repeat (2) cyc();
    check("rst_valid", {31'd0, o_valid}, 32'd0);
    check("rst_addr", o_addr, RST_A);
    check("rst_id", {31'd0, o_id}, 32'd0);
    check("rst_mis", {31'd0, o_mis}, 32'd0);

    // rq1 alone, first edge after reset release
    rst = 1'b0;
    v1 = 1'b1;
    set1(32'h100, 32'h2000, 32'h10, 1'b1, 2'd2);
    #1;
    check("solo_ready1", {31'd0, r1}, 32'd1);
    check("solo_ready0", {31'd0, r0}, 32'd0);
    cyc();
    v1 = 1'b0;
    check("solo_valid", {31'd0, o_valid}, 32'd1);
    check("solo_addr", o_addr, 32'h2010);
    check("solo_id", {31'd0, o_id}, 32'd1);
    check("solo_mis", {31'd0, o_mis}, 32'd0);

    // Continuous tie: grants alternate starting with rq0 (rq1 was served last)
    v0 = 1'b1; v1 = 1'b1;
    set0(32'h40, 32'h9999, 32'h4, 1'b0, 2'd2);
    set1(32'h7777, 32'h3000, 32'h8, 1'b1, 2'd0);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_ready0", {31'd0, r0}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check("rr_ready1", {31'd0, r1}, (i % 2 == 1) ? 32'd1 : 32'd0);
      cyc();
      check("rr_id", {31'd0, o_id}, (i % 2 == 0) ? 32'd0 : 32'd1);
      check("rr_addr", o_addr, (i % 2 == 0) ? 32'h44 : 32'h3008);
    end

    // Backpressure with 0x44 pending
    cyc();
    check("bp_first", o_addr, 32'h44);
    o_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_ready0", {31'd0, r0}, 32'd0);
      check("bp_ready1", {31'd0, r1}, 32'd0);
      cyc();
      check("bp_hold_addr", o_addr, 32'h44);
      check("bp_hold_valid", {31'd0, o_valid}, 32'd1);
    end
    o_ready = 1'b1;
    #1;
    check("bp_release_ready1", {31'd0, r1}, 32'd1);
    cyc();
    check("bp_release_addr", o_addr, 32'h3008);

    // Wrap-around sums; non-granted operands must not matter
    v0 = 1'b0; v1 = 1'b1;
    set1(32'h0, 32'hFFFF_FFFC, 32'h8, 1'b1, 2'd2);
    cyc();
    check("wrap_rs1", o_addr, 32'h0000_0004);
    v0 = 1'b1; v1 = 1'b0;
    set0(32'h10, 32'h5555, 32'hFFFF_FFF0, 1'b0, 2'd2);
    cyc();
    check("wrap_pc", o_addr, 32'h0000_0000);
    check("wrap_pc_id", {31'd0, o_id}, 32'd0);

    // Alignment table on rq1, base 0x1000
    v0 = 1'b0; v1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set1(32'h0, 32'h1000, t_imm[i], 1'b1, t_sz[i]);
      cyc();
      check("mis_addr", o_addr, 32'h1000 + t_imm[i]);
      check("mis_flag", {31'd0, o_mis}, {31'd0, t_mis[i]});
    end

    // Asynchronous reset with a stalled result in the stage
    set1(32'h0, 32'h7770, 32'h0, 1'b1, 2'd2);
    cyc();
    o_ready = 1'b0; v0 = 1'b1; v1 = 1'b1;
    #2;
    check("ar_pre_valid", {31'd0, o_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check("ar_valid", {31'd0, o_valid}, 32'd0);
    check("ar_addr", o_addr, RST_A);
    check("ar_id", {31'd0, o_id}, 32'd0);
    check("ar_ready0", {31'd0, r0}, 32'd0);
    check("ar_ready1", {31'd0, r1}, 32'd0);
    repeat (2) cyc();
    rst = 1'b0; o_ready = 1'b1;
    set0(32'h20, 32'h0, 32'h4, 1'b0, 2'd0);
    #1;
    check("ar_tie_ready0", {31'd0, r0}, 32'd1);
    check("ar_tie_ready1", {31'd0, r1}, 32'd0);
    cyc();
    check("ar_tie_id", {31'd0, o_id}, 32'd0);
    check("ar_tie_addr", o_addr, 32'h24);

    // Drain: valid drops once consumed with nothing new
    v0 = 1'b0; v1 = 1'b0;
    repeat (2) cyc();
    check("drain_valid", {31'd0, o_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
